// File: rtl/riscv_pkg.sv
// Shared definitions for the memory access stage.
//   - funct3 load/store size codes
//   - FSM state encoding of mem_access_unit
//   - alignment check helper
package riscv_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mau_state_e;

    // Byte accesses never misalign; halves need addr[0]=0; anything else
    // (word and unused codes) needs a word-aligned address.
    function automatic logic is_misaligned(input logic [2:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = addr_lo[0];
            default:     mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load data extraction.
// Ports:
//   rdata_i  [31:0]  raw word returned by data memory
//   offset_i [1:0]   byte offset of the access inside the word
//   size_i   [2:0]   funct3 size code
//   data_o   [31:0]  lane-selected and sign/zero-extended load value
module load_align
    import riscv_pkg::*;
(
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        offset_i,
    input  logic [2:0]        size_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'd0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the pipeline: retires ALU ops, issues loads/stores to the
// data memory with a req/gnt + rvalid handshake, aligns load data.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   valid_i, result_i, rd_i, wb_en_i op from EX/MEM (result_i = address)
//   read_en_i, update_en_i           load / store select (both = load)
//   store_data_i, size_i             store operand, funct3 size
//   ready_o                          high only when idle
//   dmem_req_o/we_o/addr_o/wdata_o/be_o, dmem_gnt_i, dmem_rvalid_i,
//   dmem_rdata_i                     data memory interface
//   wb_valid_o, wb_en_o, rd_o, wb_data_o, misalign_o  retire interface
module mem_access_unit
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [4:0]        rd_i,
    input  logic              wb_en_i,
    input  logic              read_en_i,
    input  logic              update_en_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [2:0]        size_i,
    output logic              ready_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_en_o,
    output logic [4:0]        rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              misalign_o
);

    function automatic logic [3:0] store_be(input logic [2:0] size,
                                            input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            F3_B, F3_BU: be = 4'b0001 << lo;
            F3_H, F3_HU: be = 4'b0011 << {lo[1], 1'b0};
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the operand across all lanes; byte enables pick the lane.
    function automatic logic [DATA_W-1:0] store_wdata(input logic [2:0] size,
                                                      input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] w;
        case (size)
            F3_B, F3_BU: w = {4{data[7:0]}};
            F3_H, F3_HU: w = {2{data[15:0]}};
            default:     w = data;
        endcase
        return w;
    endfunction

    mau_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        offset_q, offset_d;
    logic              is_load_q, is_load_d;
    logic [4:0]        op_rd_q, op_rd_d;
    logic              op_wb_en_q, op_wb_en_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_en_q, wb_en_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              misalign_q, misalign_d;

    logic [DATA_W-1:0] load_data;
    logic              mem_op;
    logic              complete;

    load_align u_load_align (
        .rdata_i  (dmem_rdata_i),
        .offset_i (offset_q),
        .size_i   (size_q),
        .data_o   (load_data)
    );

    assign mem_op   = read_en_i | update_en_i;
    // rvalid only counts once the request has been granted.
    assign complete = dmem_rvalid_i &&
                      ((state_q == ST_WAIT) || (state_q == ST_REQ && dmem_gnt_i));

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        size_d     = size_q;
        offset_d   = offset_q;
        is_load_d  = is_load_q;
        op_rd_d    = op_rd_q;
        op_wb_en_d = op_wb_en_q;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
        wb_en_d    = 1'b0;
        misalign_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    if (!mem_op) begin
                        wb_valid_d = 1'b1;
                        wb_en_d    = wb_en_i && (rd_i != 5'd0);
                        rd_d       = rd_i;
                        wb_data_d  = result_i;
                    end else if (is_misaligned(size_i, result_i[1:0])) begin
                        wb_valid_d = 1'b1;
                        misalign_d = 1'b1;
                        rd_d       = rd_i;
                        wb_data_d  = result_i;
                    end else begin
                        state_d    = ST_REQ;
                        addr_d     = {result_i[31:2], 2'b00};
                        offset_d   = result_i[1:0];
                        size_d     = size_i;
                        is_load_d  = read_en_i;
                        we_d       = ~read_en_i;
                        be_d       = store_be(size_i, result_i[1:0]);
                        wdata_d    = store_wdata(size_i, store_data_i);
                        op_rd_d    = rd_i;
                        op_wb_en_d = wb_en_i;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end
            default: ;
        endcase

        if (complete) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b1;
            rd_d       = op_rd_q;
            wb_en_d    = is_load_q && op_wb_en_q && (op_rd_q != 5'd0);
            if (is_load_q) begin
                wb_data_d = load_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            size_q     <= '0;
            offset_q   <= '0;
            is_load_q  <= 1'b0;
            op_rd_q    <= '0;
            op_wb_en_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_en_q    <= 1'b0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            size_q     <= size_d;
            offset_q   <= offset_d;
            is_load_q  <= is_load_d;
            op_rd_q    <= op_rd_d;
            op_wb_en_q <= op_wb_en_d;
            wb_valid_q <= wb_valid_d;
            wb_en_q    <= wb_en_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
        end
    end

    assign ready_o      = (state_q == ST_IDLE);
    assign dmem_req_o   = (state_q == ST_REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_en_o      = wb_en_q;
    assign rd_o         = rd_q;
    assign wb_data_o    = wb_data_q;
    assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit.
module tb_mem_access_unit;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [31:0] result_i;
    logic [4:0]  rd_i;
    logic        wb_en_i;
    logic        read_en_i;
    logic        update_en_i;
    logic [31:0] store_data_i;
    logic [2:0]  size_i;
    logic        ready_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic        wb_en_o;
    logic [4:0]  rd_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_i),
        .result_i      (result_i),
        .rd_i          (rd_i),
        .wb_en_i       (wb_en_i),
        .read_en_i     (read_en_i),
        .update_en_i   (update_en_i),
        .store_data_i  (store_data_i),
        .size_i        (size_i),
        .ready_o       (ready_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .wb_valid_o    (wb_valid_o),
        .wb_en_o       (wb_en_o),
        .rd_o          (rd_o),
        .wb_data_o     (wb_data_o),
        .misalign_o    (misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [31:0] res, input logic [4:0] rd, input logic wbe,
                            input logic rd_en, input logic up_en, input logic [2:0] sz,
                            input logic [31:0] sdata);
        valid_i      = 1'b1;
        result_i     = res;
        rd_i         = rd;
        wb_en_i      = wbe;
        read_en_i    = rd_en;
        update_en_i  = up_en;
        size_i       = sz;
        store_data_i = sdata;
    endtask

    task automatic idle_inputs();
        valid_i     = 1'b0;
        read_en_i   = 1'b0;
        update_en_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        result_i = '0; rd_i = '0; wb_en_i = 1'b0; size_i = '0; store_data_i = '0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

        // Reset state
        tick();
        tick();
        check("rst_ready",    32'(ready_o),    32'd1);
        check("rst_req",      32'(dmem_req_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_data",  wb_data_o,       32'd0);
        check("rst_addr",     dmem_addr_o,     32'd0);
        rst_n = 1'b1;
        tick();

        // ALU op
        drive_op(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, F3_W, 32'd0);
        tick();
        idle_inputs();
        check("alu_wb_valid", 32'(wb_valid_o), 32'd1);
        check("alu_wb_data",  wb_data_o,       32'h1234);
        check("alu_rd",       32'(rd_o),       32'd5);
        check("alu_wb_en",    32'(wb_en_o),    32'd1);
        check("alu_ready",    32'(ready_o),    32'd1);
        check("alu_req",      32'(dmem_req_o), 32'd0);
        tick();
        check("alu_pulse_end", 32'(wb_valid_o), 32'd0);
        check("alu_hold_data", wb_data_o,       32'h1234);
        check("alu_hold_rd",   32'(rd_o),       32'd5);

        // ALU op to x0: write suppressed
        drive_op(32'h55, 5'd0, 1'b1, 1'b0, 1'b0, F3_W, 32'd0);
        tick();
        idle_inputs();
        check("x0_wb_valid", 32'(wb_valid_o), 32'd1);
        check("x0_wb_en",    32'(wb_en_o),    32'd0);
        tick();

        // LB at 0x103, gnt on the third REQ cycle; stray rvalid without gnt
        drive_op(32'h103, 5'd7, 1'b1, 1'b1, 1'b0, F3_B, 32'd0);
        tick();
        idle_inputs();
        check("lb_req_c1",   32'(dmem_req_o), 32'd1);
        check("lb_addr_c1",  dmem_addr_o,     32'h100);
        check("lb_we",       32'(dmem_we_o),  32'd0);
        check("lb_ready_c1", 32'(ready_o),    32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEAD_BEEF;
        tick();
        dmem_rvalid_i = 1'b0;
        check("lb_req_c2",       32'(dmem_req_o), 32'd1);
        check("lb_addr_c2",      dmem_addr_o,     32'h100);
        check("lb_rvalid_ign",   32'(wb_valid_o), 32'd0);
        tick();
        check("lb_req_c3",  32'(dmem_req_o), 32'd1);
        check("lb_addr_c3", dmem_addr_o,     32'h100);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        check("lb_wait_req",   32'(dmem_req_o), 32'd0);
        check("lb_wait_ready", 32'(ready_o),    32'd0);
        check("lb_wait_nowb",  32'(wb_valid_o), 32'd0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h80FF_FF00;
        tick();
        dmem_rvalid_i = 1'b0;
        check("lb_wb_valid", 32'(wb_valid_o), 32'd1);
        check("lb_wb_data",  wb_data_o,       32'hFFFF_FF80);
        check("lb_rd",       32'(rd_o),       32'd7);
        check("lb_wb_en",    32'(wb_en_o),    32'd1);
        check("lb_ready",    32'(ready_o),    32'd1);
        tick();

        // SH at 0x202, data 0xABCD, gnt and ack together
        drive_op(32'h202, 5'd9, 1'b1, 1'b0, 1'b1, F3_H, 32'h0000_ABCD);
        tick();
        idle_inputs();
        check("sh_req",   32'(dmem_req_o), 32'd1);
        check("sh_we",    32'(dmem_we_o),  32'd1);
        check("sh_be",    32'(dmem_be_o),  32'hC);
        check("sh_wdata", dmem_wdata_o,    32'hABCD_ABCD);
        check("sh_addr",  dmem_addr_o,     32'h200);
        dmem_gnt_i = 1'b1;
        dmem_rvalid_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        check("sh_wb_valid", 32'(wb_valid_o), 32'd1);
        check("sh_wb_en",    32'(wb_en_o),    32'd0);
        check("sh_misalign", 32'(misalign_o), 32'd0);
        tick();

        // SB at 0x001, data 0x5A
        drive_op(32'h001, 5'd2, 1'b0, 1'b0, 1'b1, F3_B, 32'h1234_565A);
        tick();
        idle_inputs();
        check("sb_be",    32'(dmem_be_o), 32'h2);
        check("sb_wdata", dmem_wdata_o,   32'h5A5A_5A5A);
        check("sb_addr",  dmem_addr_o,    32'h0);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        tick();
        dmem_rvalid_i = 1'b0;
        check("sb_wb_valid", 32'(wb_valid_o), 32'd1);
        check("sb_wb_en",    32'(wb_en_o),    32'd0);
        tick();

        // LW at 0x301: misaligned, no request
        drive_op(32'h301, 5'd3, 1'b1, 1'b1, 1'b0, F3_W, 32'd0);
        tick();
        idle_inputs();
        check("lw_mis_req",      32'(dmem_req_o), 32'd0);
        check("lw_mis_wb_valid", 32'(wb_valid_o), 32'd1);
        check("lw_mis_flag",     32'(misalign_o), 32'd1);
        check("lw_mis_wb_en",    32'(wb_en_o),    32'd0);
        check("lw_mis_ready",    32'(ready_o),    32'd1);
        tick();
        check("lw_mis_flag_end", 32'(misalign_o), 32'd0);

        // Load+store both set acts as a load; LH at 0x201 misaligned
        drive_op(32'h201, 5'd6, 1'b1, 1'b1, 1'b1, F3_H, 32'd0);
        tick();
        idle_inputs();
        check("lh_mis_flag", 32'(misalign_o), 32'd1);
        check("lh_mis_req",  32'(dmem_req_o), 32'd0);
        tick();

        // LHU at 0x0, gnt and rvalid together
        drive_op(32'h0, 5'd4, 1'b1, 1'b1, 1'b0, F3_HU, 32'd0);
        tick();
        idle_inputs();
        check("lhu_req", 32'(dmem_req_o), 32'd1);
        dmem_gnt_i = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h0000_8001;
        tick();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        check("lhu_wb_valid", 32'(wb_valid_o), 32'd1);
        check("lhu_wb_data",  wb_data_o,       32'h0000_8001);
        check("lhu_wb_en",    32'(wb_en_o),    32'd1);
        check("lhu_ready",    32'(ready_o),    32'd1);
        tick();

        // LH at 0x2 with both load+store set: upper half sign-extended, no write
        drive_op(32'h2, 5'd8, 1'b1, 1'b1, 1'b1, F3_H, 32'hFFFF_FFFF);
        tick();
        idle_inputs();
        check("lh_we", 32'(dmem_we_o), 32'd0);
        dmem_gnt_i = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h8001_1234;
        tick();
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        check("lh_wb_data", wb_data_o, 32'hFFFF_8001);
        tick();

        // rvalid in IDLE is ignored
        dmem_rvalid_i = 1'b1;
        tick();
        dmem_rvalid_i = 1'b0;
        check("idle_rvalid_ign", 32'(wb_valid_o), 32'd0);

        // Reset in REQ drops the request at once
        drive_op(32'h400, 5'd10, 1'b1, 1'b1, 1'b0, F3_W, 32'd0);
        tick();
        idle_inputs();
        check("rreq_req_before", 32'(dmem_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rreq_req_drop", 32'(dmem_req_o), 32'd0);
        check("rreq_ready",    32'(ready_o),    32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset in WAIT; late rvalid after reset does not retire
        drive_op(32'h404, 5'd11, 1'b1, 1'b1, 1'b0, F3_W, 32'd0);
        tick();
        idle_inputs();
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        check("rwait_ready_before", 32'(ready_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rwait_req",   32'(dmem_req_o), 32'd0);
        check("rwait_ready", 32'(ready_o),    32'd1);
        tick();
        rst_n = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1111_2222;
        tick();
        dmem_rvalid_i = 1'b0;
        check("rwait_no_retire", 32'(wb_valid_o), 32'd0);
        check("rwait_wb_data",   wb_data_o,       32'd0);
        tick();
        check("rwait_no_retire2", 32'(wb_valid_o), 32'd0);
        check("rwait_idle_ready", 32'(ready_o),    32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
